instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the width of the byte address counter.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the output buffer entries (power of two, >=2).
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: asynchronous, active-low.
REQ-005 Port clear  input  1  is the synchronous flush and address restart.
REQ-006 Port in_valid  input  1  indicates that an instruction request is present.
REQ-007 Port in_ready  output  1  indicates that the block can accept a request.
REQ-008 Port in_class  input  2  selects the format: 00 R-type, 01 LOAD, 10 STORE, 11 BRANCH.
REQ-009 Ports in_rd, in_rs1, in_rs2  input  5 each  are the register indices.
REQ-010 Ports in_funct3  input  3  and in_funct7  input  7  are the function fields.
REQ-011 Port in_imm  input  13  is the signed immediate (LOAD/STORE use [11:0]; BRANCH uses [12:1]).
REQ-012 Port out_valid  output  1  indicates that an encoded word is available.
REQ-013 Port out_ready  input  1  indicates that the consumer accepts the word.
REQ-014 Port out_instr  output  32  is the encoded instruction word.
REQ-015 Port out_addr  output  ADDR_W  is the byte address assigned to out_instr.
REQ-016 Port err  output  1  is a sticky flag for a BRANCH request with in_imm[0]=1.

Function
REQ-017 A request SHALL be accepted in any cycle with in_valid=1, in_ready=1 and clear=0.
REQ-018 in_ready SHALL equal (buffer not full); it SHALL NOT depend on out_ready, so there is no push through a full buffer even when a pop occurs in the same cycle.
REQ-019 Encoding SHALL be combinational at acceptance, and the 32-bit word SHALL be stored in the buffer, as follows:
  - R: funct7|rs2|rs1|funct3|rd|0110011.
  - LOAD: imm[11:0]|rs1|funct3|rd|0000011.
  - STORE: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011.
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011.
  - Fields not used by a format SHALL be ignored.
REQ-020 Latency SHALL be one cycle: a word accepted in cycle N is visible at the head with out_valid=1 in cycle N+1; there is no same-cycle bypass.
REQ-021 Each accepted request SHALL capture the current address counter value with its word; the counter SHALL then advance by 4, wrapping modulo 2^ADDR_W, with bits [1:0] always 0.
REQ-022 The buffer SHALL pop on out_valid & out_ready and SHALL deliver words strictly in FIFO order.
REQ-023 out_instr and out_addr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Simultaneous push and pop with the buffer neither full nor empty SHALL leave the occupancy unchanged.
REQ-025 A BRANCH request with in_imm[0]=1 SHALL still be accepted and encoded with bit 0 dropped, and SHALL set err; err SHALL clear only on clear or reset.
REQ-026 clear=1 SHALL, at the next edge, empty the buffer, zero the counter and clear err; a request presented in the same cycle SHALL be discarded; in_ready SHALL stay as computed.

Reset
REQ-027 While rst_n=0, out_valid=0, err=0, the address counter=0, the buffer SHALL be empty and in_ready SHALL be 1 after reset is released.
REQ-028 Reset asserted mid-stream SHALL discard all buffered words immediately and asynchronously.
REQ-029 out_instr and out_addr SHALL read 0 while the buffer is empty after reset.

Structure
REQ-030 Package instr_enc_pkg SHALL hold the opcode constants (OP_R=0110011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011) and the in_class encodings.
REQ-031 The buffer SHALL be one sub-module, instr_fifo (width 32+ADDR_W, depth DEPTH, asynchronous active-low reset).
REQ-032 The encoder SHALL be combinational logic in instr_encoder, with no extra pipeline stage.

Verification
REQ-033 Scenario, R-type: class 00, rd3, rs1 1, rs2 2, f3 0, f7 0 -> out_instr 0x002081B3, out_addr 0x00.
REQ-034 Scenario, LOAD then STORE: class 01, rd5, rs1 2, f3 010, imm 8 -> 0x00812283 at addr 0x00; then class 10, rs1 2, rs2 6, f3 010, imm 12 -> 0x00612623 at addr 0x04.
REQ-035 Scenario, BRANCH: class 11, rs1 1, rs2 2, f3 0, imm -8 -> 0xFE208CE3, err=0; repeat with imm -7 -> same word, err=1.
REQ-036 Scenario, backpressure: out_ready=0, push 3 requests -> the first 2 are accepted, then in_ready=0; hold the third; raise out_ready -> the 3 words are delivered in order at addresses 0x00, 0x04, 0x08.
REQ-037 Scenario, wrap: ADDR_W=4, push 5 requests -> addresses 0x0, 0x4, 0x8, 0xC, 0x0.
REQ-038 Scenario, clear/reset: with 2 words buffered, pulse clear together with in_valid -> out_valid=0 next cycle, the next accepted request gets addr 0; drop rst_n mid-stream -> out_valid falls with no clock edge.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// rtl/instr_enc_pkg.sv - opcode constants and instruction class encodings for instr_encoder
package instr_enc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        CLS_R      = 2'b00,
        CLS_LOAD   = 2'b01,
        CLS_STORE  = 2'b10,
        CLS_BRANCH = 2'b11
    } instr_class_e;

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - small synchronous FIFO holding encoded words with their addresses
module instr_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= wdata;
        end
    end

    // An empty buffer presents zeros rather than stale storage.
    assign rdata = empty ? '0 : mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes R/LOAD/STORE/BRANCH requests into 32-bit words with byte addresses
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [12:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    localparam int FW = INSTR_W + ADDR_W;

    instr_class_e      cls;
    logic [31:0]       enc_word;
    logic [ADDR_W-1:0] addr_q;
    logic              accept;
    logic              full;
    logic              empty;
    logic [FW-1:0]     head;

    assign cls      = instr_class_e'(in_class);
    assign in_ready = !full;
    assign accept   = in_valid && in_ready && !clear;

    always_comb begin
        enc_word = '0;
        case (cls)
            CLS_R:      enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            CLS_LOAD:   enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            CLS_STORE:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
            CLS_BRANCH: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                    in_imm[4:1], in_imm[11], OP_BRANCH};
            default:    enc_word = '0;
        endcase
    end

    // Address counter steps by one word per accepted request and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            err    <= 1'b0;
        end else if (clear) begin
            addr_q <= '0;
            err    <= 1'b0;
        end else if (accept) begin
            addr_q <= addr_q + ADDR_W'(4);
            if (cls == CLS_BRANCH && in_imm[0]) begin
                err <= 1'b1;
            end
        end
    end

    instr_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (accept),
        .wdata ({enc_word, addr_q}),
        .pop   (out_valid && out_ready),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;
    assign out_instr = head[FW-1:ADDR_W];
    assign out_addr  = head[ADDR_W-1:0];

endmodule
